pim_ctrl: RTL and testbench

Memory-mapped PIM controller sitting directly downstream of the core-side PIM bus port. It accepts registered address/write-data/strobe traffic from the system bus. It buffers weights and activations written by the core or DMA, then sequences the analog PIM macro through a weight-load and compute pass. It captures per-activation results for readback at `PIM_R`.

---
 rtl/pim_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pim_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_ctrl.sv
// pim_ctrl: memory-mapped sequencer for an analog PIM macro.
// Optional feature macro PIM_ACC_EN: accumulate-on-capture via CTRL bit1.
module pim_ctrl #(
  parameter int unsigned     XLEN             = 32,
  parameter int unsigned     N_WORDS          = 8,
  parameter int unsigned     CMP_LAT          = 4,
  parameter logic [XLEN-1:0] PIM_CTRL         = 32'h4000_0010,
  parameter logic [XLEN-1:0] PIM_R            = 32'h4000_0020,
  parameter logic [XLEN-1:0] PIM_W_WEIGHT     = 32'h4000_0040,
  parameter logic [XLEN-1:0] PIM_W_ACTIVATION = 32'h4000_0080,
  parameter logic [XLEN-1:0] PIM_W_KEY        = 32'h4000_0100,
  parameter logic [XLEN-1:0] PIM_W_VREF       = 32'h4000_0200,
  parameter logic [XLEN-1:0] PIM_W_MODE       = 32'h4000_0400
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [XLEN-1:0]            i_pim_addr,
  input  logic [XLEN-1:0]            i_pim_wr_data,
  input  logic                       i_pim_write,
  input  logic                       i_pim_read,
  output logic [XLEN-1:0]            o_pim_rd_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_mac_we,
  output logic [$clog2(N_WORDS)-1:0] o_mac_row,
  output logic [31:0]                o_mac_wdata,
  output logic [31:0]                o_mac_act,
  output logic                       o_mac_cmp,
  output logic [31:0]                o_mac_key,
  output logic [31:0]                o_mac_vref,
  output logic [3:0]                 o_mac_mode,
  input  logic [31:0]                i_mac_res
);

  localparam int unsigned AW = $clog2(N_WORDS);
  localparam int unsigned SW = $clog2(CMP_LAT + 1);
  localparam logic [AW-1:0] LAST  = AW'(N_WORDS - 1);
  localparam logic [SW-1:0] SLAST = SW'(CMP_LAT);

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_COMP, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   cnt, cnt_n;
  logic [SW-1:0]   sub, sub_n;
  logic [31:0]     wbuf [N_WORDS];
  logic [31:0]     abuf [N_WORDS];
  logic [31:0]     res  [N_WORDS];
  logic [AW-1:0]   wptr, aptr, rptr;
  logic            done_q;
  logic            idle, wr_ok, start, clr;
  logic            rd_r, rd_c, cap_en;
  logic [31:0]     wd, cap;
  logic [XLEN-1:0] status, rd_n;

  assign idle   = (state == S_IDLE);
  assign o_busy = !idle;
  assign wd     = i_pim_wr_data[31:0];
  assign wr_ok  = i_pim_write && idle;
  assign start  = wr_ok && (i_pim_addr == PIM_CTRL) && wd[0];
  assign clr    = wr_ok && (i_pim_addr == PIM_CTRL) && wd[2];
  assign rd_r   = i_pim_read && (i_pim_addr == PIM_R);
  assign rd_c   = i_pim_read && (i_pim_addr == PIM_CTRL);
  assign cap_en = (state == S_COMP) && (sub == SLAST);

`ifdef PIM_ACC_EN
  logic acc;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   acc <= 1'b0;
    else if (start) acc <= wd[1];
  end
  assign cap = acc ? res[cnt] + i_mac_res : i_mac_res;
`else
  assign cap = i_mac_res;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sub_n   = sub;
    unique case (state)
      S_IDLE: if (start) begin
        state_n = S_LOAD;
        cnt_n   = '0;
      end
      S_LOAD: if (cnt == LAST) begin
        state_n = S_COMP;
        cnt_n   = '0;
        sub_n   = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      S_COMP: if (sub == SLAST) begin
        sub_n = '0;
        if (cnt == LAST) state_n = S_DONE;
        else             cnt_n   = cnt + 1'b1;
      end else begin
        sub_n = sub + 1'b1;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    status       = '0;
    status[11:8] = 4'(wptr);
    status[7:4]  = 4'(aptr);
    status[1]    = done_q;
    status[0]    = !idle;
  end

  always_comb begin
    rd_n = '0;
    unique case (1'b1)
      rd_r:    rd_n = XLEN'(res[rptr]);
      rd_c:    rd_n = status;
      default: rd_n = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      sub           <= '0;
      wptr          <= '0;
      aptr          <= '0;
      rptr          <= '0;
      done_q        <= 1'b0;
      o_mac_key     <= '0;
      o_mac_vref    <= '0;
      o_mac_mode    <= '0;
      o_pim_rd_data <= '0;
      for (int i = 0; i < N_WORDS; i++) begin
        wbuf[i] <= '0;
        abuf[i] <= '0;
        res[i]  <= '0;
      end
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sub   <= sub_n;
      if (wr_ok && i_pim_addr == PIM_W_WEIGHT) begin
        wbuf[wptr] <= wd;
        wptr       <= wptr + 1'b1;
      end
      if (wr_ok && i_pim_addr == PIM_W_ACTIVATION) begin
        abuf[aptr] <= wd;
        aptr       <= aptr + 1'b1;
      end
      if (wr_ok && i_pim_addr == PIM_W_KEY)  o_mac_key  <= wd;
      if (wr_ok && i_pim_addr == PIM_W_VREF) o_mac_vref <= wd;
      if (wr_ok && i_pim_addr == PIM_W_MODE) o_mac_mode <= wd[3:0];
      if (cap_en) res[cnt] <= cap;
      if (i_pim_read) o_pim_rd_data <= rd_n;
      // the write wins the read pointer when both land together
      if (start || clr)  rptr <= '0;
      else if (rd_r)     rptr <= rptr + 1'b1;
      if (state_n == S_DONE) done_q <= 1'b1;
      else if (start)        done_q <= 1'b0;
      if (clr) begin
        wptr <= '0;
        aptr <= '0;
`ifdef PIM_ACC_EN
        for (int i = 0; i < N_WORDS; i++) res[i] <= '0;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mac_we    <= 1'b0;
      o_mac_row   <= '0;
      o_mac_wdata <= '0;
      o_mac_act   <= '0;
      o_mac_cmp   <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_mac_we    <= (state_n == S_LOAD);
      o_mac_row   <= (state_n == S_LOAD) ? cnt_n : '0;
      o_mac_wdata <= (state_n == S_LOAD) ? wbuf[cnt_n] : '0;
      o_mac_act   <= (state_n == S_COMP) ? abuf[cnt_n] : '0;
      o_mac_cmp   <= (state_n == S_COMP) && (sub_n == '0);
      o_done      <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_pim_ctrl.sv
// tb_pim_ctrl: directed bench for pim_ctrl with a cycle-level reference model.
// Honours PIM_ACC_EN when the design is built with it.
module tb_pim_ctrl;

  localparam int N  = 8;
  localparam int L  = 4;
  localparam int TD = N + N * (L + 1) + 1;

  localparam logic [31:0] A_CTRL = 32'h4000_0010;
  localparam logic [31:0] A_R    = 32'h4000_0020;
  localparam logic [31:0] A_W    = 32'h4000_0040;
  localparam logic [31:0] A_A    = 32'h4000_0080;
  localparam logic [31:0] A_KEY  = 32'h4000_0100;
  localparam logic [31:0] A_VREF = 32'h4000_0200;
  localparam logic [31:0] A_MODE = 32'h4000_0400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_pim_addr, i_pim_wr_data;
  logic        i_pim_write, i_pim_read;
  logic [31:0] o_pim_rd_data;
  logic        o_busy, o_done, o_mac_we, o_mac_cmp;
  logic [2:0]  o_mac_row;
  logic [31:0] o_mac_wdata, o_mac_act, o_mac_key, o_mac_vref;
  logic [3:0]  o_mac_mode;
  logic [31:0] mac_res;

  always #5 clk = ~clk;

  pim_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pim_addr   (i_pim_addr),
    .i_pim_wr_data(i_pim_wr_data),
    .i_pim_write  (i_pim_write),
    .i_pim_read   (i_pim_read),
    .o_pim_rd_data(o_pim_rd_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_mac_we     (o_mac_we),
    .o_mac_row    (o_mac_row),
    .o_mac_wdata  (o_mac_wdata),
    .o_mac_act    (o_mac_act),
    .o_mac_cmp    (o_mac_cmp),
    .o_mac_key    (o_mac_key),
    .o_mac_vref   (o_mac_vref),
    .o_mac_mode   (o_mac_mode),
    .i_mac_res    (mac_res)
  );

  // macro stand-in: result valid only exactly L cycles after cmp
  int          lat;
  logic [31:0] lact;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat  <= 0;
      lact <= '0;
    end else if (o_mac_cmp) begin
      lat  <= 1;
      lact <= o_mac_act;
    end else if (lat > 0 && lat < L) begin
      lat <= lat + 1;
    end else begin
      lat <= 0;
    end
  end
  assign mac_res = (lat == L) ? lact + 32'h100 : 32'hBAD0_0BAD;

  // reference model state
  logic [31:0] wm [N];
  logic [31:0] am [N];
  logic [31:0] rm [N];
  int          wp, ap, rp;
  logic [31:0] key_m, vref_m;
  logic [3:0]  mode_m;
  bit          done_m, acc_m, pass_on, chk_on;
  int          pass_s;
  int          ec = 0;
  int          n_chk = 0, n_fail = 0;
  int          n_we, n_cmp, first_cmp, last_cmp, done_t;
  logic [31:0] row0, row1, d;

  always @(posedge clk) ec <= ec + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      wm[i] = '0;
      am[i] = '0;
      rm[i] = '0;
    end
    wp = 0; ap = 0; rp = 0;
    key_m = '0; vref_m = '0; mode_m = '0;
    done_m = 0; acc_m = 0; pass_on = 0;
    pass_s = 0;
  endtask

  task automatic stats_clear();
    n_we = 0; n_cmp = 0; first_cmp = -1;
    last_cmp = -1; done_t = -1;
    row0 = '0; row1 = '0;
  endtask

  task automatic cyc_check();
    int t, c;
    bit on;
    logic e_we, e_cmp, e_done, e_busy;
    logic [31:0] e_row, e_wd, e_act;
    t = ec - pass_s + 1;
    on = pass_on && rst_n;
    e_busy = on && t >= 1 && t <= TD;
    e_we = on && t >= 1 && t <= N;
    e_row = '0;
    e_wd = '0;
    if (e_we) begin
      e_row = 32'(t - 1);
      e_wd = wm[t-1];
    end
    c = t - N - 1;
    e_act = '0;
    e_cmp = 1'b0;
    if (on && c >= 0 && c < N * (L + 1)) begin
      e_act = am[c / (L + 1)];
      e_cmp = (c % (L + 1)) == 0;
    end
    e_done = on && t == TD;
    chk("busy", 32'(o_busy), 32'(e_busy));
    chk("mac_we", 32'(o_mac_we), 32'(e_we));
    chk("mac_row", 32'(o_mac_row), e_row);
    chk("mac_wdata", o_mac_wdata, e_wd);
    chk("mac_act", o_mac_act, e_act);
    chk("mac_cmp", 32'(o_mac_cmp), 32'(e_cmp));
    chk("done", 32'(o_done), 32'(e_done));
    chk("key", o_mac_key, key_m);
    chk("vref", o_mac_vref, vref_m);
    chk("mode", 32'(o_mac_mode), 32'(mode_m));
    if (on) begin
      if (o_mac_we) n_we++;
      if (o_mac_cmp) begin
        n_cmp++;
        if (first_cmp < 0) first_cmp = t;
        last_cmp = t;
      end
      if (o_done) done_t = t;
      if (t == 1) row0 = o_mac_wdata;
      if (t == 2) row1 = o_mac_wdata;
      if (t == TD) begin
        for (int j = 0; j < N; j++)
          rm[j] = acc_m ? rm[j] + am[j] + 32'h100 : am[j] + 32'h100;
        done_m = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_on) cyc_check();
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    int t;
    bit ok;
    @(negedge clk);
    i_pim_addr = a;
    i_pim_wr_data = v;
    i_pim_write = 1'b1;
    t = ec - pass_s + 1;
    ok = !(pass_on && t >= 1 && t <= TD);
    if (ok) begin
      if (a == A_W) begin wm[wp] = v; wp = (wp + 1) % N; end
      if (a == A_A) begin am[ap] = v; ap = (ap + 1) % N; end
      if (a == A_KEY) key_m = v;
      if (a == A_VREF) vref_m = v;
      if (a == A_MODE) mode_m = v[3:0];
      if (a == A_CTRL && v[2]) begin
        wp = 0; ap = 0; rp = 0;
`ifdef PIM_ACC_EN
        for (int j = 0; j < N; j++) rm[j] = '0;
`endif
      end
      if (a == A_CTRL && v[0]) begin
        pass_on = 1;
        pass_s = ec + 1;
        done_m = 0;
        rp = 0;
`ifdef PIM_ACC_EN
        acc_m = v[1];
`else
        acc_m = 0;
`endif
      end
    end
    @(negedge clk);
    i_pim_write = 1'b0;
    i_pim_addr = '0;
    i_pim_wr_data = '0;
  endtask

  task automatic rd(input string nm, input logic [31:0] a,
                    output logic [31:0] q);
    logic [31:0] e;
    int t;
    @(negedge clk);
    t = ec - pass_s + 1;
    e = '0;
    if (a == A_R) begin
      e = rm[rp];
      rp = (rp + 1) % N;
    end else if (a == A_CTRL) begin
      e = {20'b0, 4'(wp), 4'(ap), 2'b0,
           done_m || (pass_on && t >= TD),
           pass_on && t >= 1 && t <= TD};
    end
    i_pim_addr = a;
    i_pim_read = 1'b1;
    @(negedge clk);
    i_pim_read = 1'b0;
    i_pim_addr = '0;
    q = o_pim_rd_data;
    chk(nm, q, e);
  endtask

  task automatic start_pass(input logic [31:0] v);
    stats_clear();
    wr(A_CTRL, v);
  endtask

  task automatic wait_pass();
    int n = 0;
    while (pass_on && (ec - pass_s + 1) <= TD && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pass_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic wait_t(input int tt);
    int n = 0;
    while ((ec - pass_s + 1) < tt && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic do_reset_check(input string nm);
    chk({nm, "_busy"}, 32'(o_busy), 32'd0);
    chk({nm, "_done"}, 32'(o_done), 32'd0);
    chk({nm, "_we"}, 32'(o_mac_we), 32'd0);
    chk({nm, "_cmp"}, 32'(o_mac_cmp), 32'd0);
    chk({nm, "_row"}, 32'(o_mac_row), 32'd0);
    chk({nm, "_wdata"}, o_mac_wdata, 32'd0);
    chk({nm, "_act"}, o_mac_act, 32'd0);
    chk({nm, "_key"}, o_mac_key, 32'd0);
    chk({nm, "_rd"}, o_pim_rd_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_pim_addr = '0;
    i_pim_wr_data = '0;
    i_pim_write = 1'b0;
    i_pim_read = 1'b0;
    chk_on = 0;
    model_clear();
    stats_clear();
    repeat (3) @(negedge clk);
    do_reset_check("rst");
    rst_n = 1'b1;
    chk_on = 1;
    rd("ctrl_after_rst", A_CTRL, d);
    chk("ctrl_after_rst_lit", d, 32'h0);

    // full pass
    for (int i = 0; i < N; i++) wr(A_W, 32'h11 + i);
    for (int i = 0; i < N; i++) wr(A_A, 32'h21 + i);
    wr(A_KEY, 32'hCAFE_F00D);
    wr(A_VREF, 32'h55);
    wr(A_MODE, 32'h1F);
    chk("mode_lit", 32'(o_mac_mode), 32'hF);
    start_pass(32'h1);
    wait_pass();
    chk("n_we_lit", n_we, 8);
    chk("n_cmp_lit", n_cmp, 8);
    chk("first_cmp_lit", first_cmp, 9);
    chk("last_cmp_lit", last_cmp, 44);
    chk("done_t_lit", done_t, 49);
    chk("row0_lit", row0, 32'h11);
    for (int i = 0; i < N; i++) begin
      rd("res_rd", A_R, d);
      chk("res_lit", d, 32'h121 + i);
    end
    rd("res_wrap", A_R, d);
    chk("res_wrap_lit", d, 32'h121);
    rd("ctrl_done", A_CTRL, d);
    chk("ctrl_done_lit", d, 32'h2);

    // busy lockout
    start_pass(32'h1);
    wait_t(20);
    wr(A_W, 32'hFF);
    wr(A_CTRL, 32'h5);
    rd("ctrl_busy", A_CTRL, d);
    chk("ctrl_busy_lit", d, 32'h1);
    wait_pass();
    chk("lock_done_t_lit", done_t, 49);
    chk("lock_n_cmp_lit", n_cmp, 8);
    rd("lock_res", A_R, d);
    chk("lock_res_lit", d, 32'h121);

    // pointer wrap
    wr(A_CTRL, 32'h4);
    for (int i = 0; i < 9; i++) wr(A_W, 32'hA0 + i);
    rd("ctrl_wrap", A_CTRL, d);
    chk("ctrl_wrap_lit", d, 32'h102);
    start_pass(32'h1);
    wait_pass();
    chk("wrap_row0_lit", row0, 32'hA8);
    chk("wrap_row1_lit", row1, 32'hA1);

    // reset in the middle of a pass
    start_pass(32'h1);
    wait_t(30);
    @(negedge clk);
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    model_clear();
    #1;
    do_reset_check("mid_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("no_done_lit", done_t, -1);
    rd("rst_res", A_R, d);
    chk("rst_res_lit", d, 32'h0);

    // accumulate passes
    for (int i = 0; i < N; i++) wr(A_A, 32'h21 + i);
    start_pass(32'h3);
    wait_pass();
    start_pass(32'h3);
    wait_pass();
    for (int i = 0; i < N; i++) begin
      rd("acc_rd", A_R, d);
`ifdef PIM_ACC_EN
      chk("acc_lit", d, 2 * (32'h121 + i));
`else
      chk("acc_lit", d, 32'h121 + i);
`endif
    end

    repeat (2) @(negedge clk);
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
